// File: rtl/shift_rr_sched.sv
// rtl/shift_rr_sched.sv - two-client round-robin scheduler around a 1-bit-per-cycle shift stage
// Optional build macro: SHIFT_ROTATE_EN (vacated bit takes the shifted-out bit, giving a rotate)
module shift_rr_sched (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_data,
   input  logic [2:0] req0_amt,
   input  logic       req0_dir,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_data,
   input  logic [2:0] req1_amt,
   input  logic       req1_dir,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_id,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t     state;
   logic       prio;
   logic [7:0] work;
   logic [2:0] cnt;
   logic       dir_r;
   logic       id_r;

   logic       idle;
   logic       grant1;
   logic       fire;
   logic [2:0] pick_amt;
   logic       fill_l;
   logic       fill_r;
   logic [7:0] step;

   // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
   assign idle       = (state == IDLE) && !rst;
   assign grant1     = req1_valid && (!req0_valid || prio);
   assign req1_ready = idle && grant1;
   assign req0_ready = idle && req0_valid && !grant1;
   assign fire       = req0_ready || req1_ready;
   assign pick_amt   = grant1 ? req1_amt : req0_amt;

   always_comb begin
      fill_l = 1'b0;
      fill_r = 1'b0;
`ifdef SHIFT_ROTATE_EN
      fill_l = work[7];
      fill_r = work[0];
`endif
      step = dir_r ? {fill_r, work[7:1]} : {work[6:0], fill_l};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         prio  <= 1'b0;
         work  <= 8'h00;
         cnt   <= 3'd0;
         dir_r <= 1'b0;
         id_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fire) begin
                  id_r  <= grant1;
                  prio  <= ~grant1;
                  work  <= grant1 ? req1_data : req0_data;
                  dir_r <= grant1 ? req1_dir : req0_dir;
                  cnt   <= pick_amt;
                  state <= (pick_amt == 3'd0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               work <= step;
               cnt  <= cnt - 3'd1;
               if (cnt == 3'd1) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_data  = work;
   assign out_id    = id_r;

endmodule

// File: tb/tb_shift_rr_sched.sv
// tb/tb_shift_rr_sched.sv - scoreboard bench for shift_rr_sched
// Build with SHIFT_ROTATE_EN defined to check the rotate variant.
module tb_shift_rr_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
   logic [2:0] req0_amt = 3'd0, req1_amt = 3'd0;
   logic       req0_dir = 1'b0, req1_dir = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_id;
   logic       busy;

   shift_rr_sched dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
      .req0_amt(req0_amt), .req0_dir(req0_dir),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
      .req1_amt(req1_amt), .req1_dir(req1_dir),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_id(out_id), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       id;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   grants[$];
   int   accs[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   rise = 0;
   bit   prev_v = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a, input logic dr);
`ifdef SHIFT_ROTATE_EN
      logic [15:0] w;
      w = dr ? ({d, d} >> a) : ({d, d} << a);
      return dr ? w[7:0] : w[15:8];
`else
      return dr ? (d >> a) : (d << a);
`endif
   endfunction

   // Monitor: every consumed result must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst) prev_v = 1'b0;
      else begin
         if (out_valid && !prev_v) begin
            rise = cyc;
            if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
         end
         if (out_valid && out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_data", int'(out_data), int'(e.data));
            chk("out_id", int'(out_id), int'(e.id));
            chk("latency", rise, e.cyc);
         end
         prev_v = out_valid;
      end
   end

   task automatic drive(input bit r, input logic [7:0] d, input logic [2:0] a,
                        input logic dr, input logic [7:0] e);
      bit got = 0;
      @(negedge clk);
      if (r) begin req1_valid = 1; req1_data = d; req1_amt = a; req1_dir = dr; end
      else   begin req0_valid = 1; req0_data = d; req0_amt = a; req0_dir = dr; end
      for (int t = 0; t < 300 && !got; t++) begin
         #1;
         if (r ? req1_ready : req0_ready) begin
            got = 1;
            sb.push_back('{data: e, id: r, cyc: cyc + int'(a) + 1});
            grants.push_back(int'(r));
            accs.push_back(cyc);
         end else @(negedge clk);
      end
      if (!got) begin
         n_chk++; n_fail++;
         $display("FAIL drive_timeout: requester %0d never granted", r);
      end
      @(posedge clk); #1;
      if (r) req1_valid = 0; else req0_valid = 0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk); #3;
         ok = !busy && sb.size() == 0;
      end
      chk("wait_idle", int'(ok), 1);
   endtask

   int r_cyc;
   bit seen;

   initial begin
      // Reset: requesters asking while in reset must see no ready
      req0_valid = 1; req1_valid = 1;
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      chk("rst_req0_ready", int'(req0_ready), 0);
      chk("rst_req1_ready", int'(req1_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_id", int'(out_id), 0);
      chk("rst_busy", int'(busy), 0);
      req0_valid = 0; req1_valid = 0;
      @(posedge clk); #1 rst = 0;

`ifdef SHIFT_ROTATE_EN
      drive(0, 8'hB5, 3'd3, 1'b0, 8'hAD);
`else
      drive(0, 8'hB5, 3'd3, 1'b0, 8'hA8);
`endif
      wait_idle();
      drive(1, 8'h81, 3'd0, 1'b1, 8'h81);
      wait_idle();

      // Both requesting continuously: strict alternation starting at requester 0
      grants.delete(); accs.delete();
      fork
         begin drive(0, 8'h0F, 3'd1, 1'b0, 8'h1E); drive(0, 8'h33, 3'd1, 1'b0, 8'h66); end
`ifdef SHIFT_ROTATE_EN
         begin drive(1, 8'hF0, 3'd1, 1'b1, 8'h78); drive(1, 8'hC3, 3'd1, 1'b1, 8'hE1); end
`else
         begin drive(1, 8'hF0, 3'd1, 1'b1, 8'h78); drive(1, 8'hC3, 3'd1, 1'b1, 8'h61); end
`endif
      join
      chk("alt_count", grants.size(), 4);
      if (grants.size() == 4) begin
         for (int k = 0; k < 4; k++) chk("alt_grant", grants[k], k % 2);
         for (int k = 1; k < 4; k++) chk("alt_spacing", accs[k] - accs[k-1], 3);
      end
      wait_idle();

      // Backpressure: DONE holds with both readies low
      grants.delete(); accs.delete();
      out_ready = 0;
      fork
`ifdef SHIFT_ROTATE_EN
         drive(0, 8'h5A, 3'd2, 1'b1, 8'h96);
`else
         drive(0, 8'h5A, 3'd2, 1'b1, 8'h16);
`endif
         drive(1, 8'h3C, 3'd1, 1'b0, 8'h78);
      join_none
      seen = 0;
      for (int t = 0; t < 50 && !seen; t++) begin @(negedge clk); #2; seen = out_valid; end
      chk("bp_valid_seen", int'(seen), 1);
      for (int t = 0; t < 10; t++) begin
         @(negedge clk); #2;
`ifdef SHIFT_ROTATE_EN
         chk("bp_data", int'(out_data), 8'h96);
`else
         chk("bp_data", int'(out_data), 8'h16);
`endif
         chk("bp_id", int'(out_id), 0);
         chk("bp_req0_ready", int'(req0_ready), 0);
         chk("bp_req1_ready", int'(req1_ready), 0);
         chk("bp_busy", int'(busy), 1);
      end
      @(negedge clk);
      out_ready = 1;
      r_cyc = cyc;
      wait fork;
      chk("bp_grants", grants.size(), 2);
      if (grants.size() == 2) begin
         chk("bp_second_grant", grants[1], 1);
         chk("bp_regrant_cycle", accs[1], r_cyc + 1);
      end
      wait_idle();

      // Reset during the 2nd SHIFT cycle discards the request and clears prio
      drive(0, 8'h99, 3'd5, 1'b0, 8'h20);
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk); #2;
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_out_data", int'(out_data), 0);
      chk("mid_rst_out_id", int'(out_id), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_sb", sb.size(), 1);
      if (sb.size() != 0) void'(sb.pop_back());
      repeat (8) @(negedge clk);
      grants.delete(); accs.delete();
      fork
         drive(0, 8'h01, 3'd0, 1'b0, 8'h01);
         drive(1, 8'h02, 3'd0, 1'b0, 8'h02);
      join
      chk("post_rst_grants", grants.size(), 2);
      if (grants.size() == 2) chk("post_rst_first_grant", grants[0], 0);
      wait_idle();

      // Sweep every amount and direction on single-bit operands
      for (int a = 0; a < 8; a++)
         for (int dr = 0; dr < 2; dr++) begin
            drive(0, 8'h01, 3'(a), 1'(dr), model(8'h01, 3'(a), 1'(dr)));
            drive(0, 8'h80, 3'(a), 1'(dr), model(8'h80, 3'(a), 1'(dr)));
         end
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
